// File: rtl/aznable_pkg.sv
// Shared types and constants for the Aznable system loader and memory blocks.
package aznable_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } dl_state_t;

  localparam logic [7:0] IDX_PGROM = 8'd0;
  localparam logic [7:0] IDX_CHROM = 8'd1;

  localparam int unsigned PGROM_AW = 14;
  localparam int unsigned CHROM_AW = 11;

  // True when addr lies below 2^aw.
  function automatic logic addr_fits(input logic [24:0] addr, input int unsigned aw);
    return (addr >> aw) == 25'd0;
  endfunction

endpackage

// File: rtl/download_ctrl.sv
// Turns the HPS ioctl download stream into registered ROM write strobes,
// range-checks each byte, keeps a checksum/count and drives the system reset.
module download_ctrl
  import aznable_pkg::*;
#(
  parameter int unsigned PG_AW      = PGROM_AW,
  parameter int unsigned CH_AW      = CHROM_AW,
  parameter int unsigned RESET_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [13:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic [7:0]  dn_index,
  output logic        dn_wr,
  output logic        sys_reset,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  checksum,
  output logic [14:0] byte_count
);

  localparam int unsigned CNT_W = $clog2(RESET_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_HOLD - 1);

  dl_state_t       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            dl_q;
  logic            rise;

  logic [13:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic [7:0]  dn_index_q, dn_index_d;
  logic        dn_wr_d, dn_wr_q;
  logic        overflow_q, overflow_d;
  logic [7:0]  checksum_q, checksum_d;
  logic [14:0] count_q, count_d;

  logic [7:0]  idx;
  logic        cand, known_idx, fits, accept, ovf_hit;
  logic [7:0]  sum_base;
  logic [14:0] cnt_base;

  assign rise = ioctl_download & ~dl_q;

  // The rise cycle already carries a write, so use the live index there.
  assign idx       = rise ? ioctl_index : dn_index_q;
  assign cand      = ioctl_wr & ioctl_download;
  assign known_idx = (idx == IDX_PGROM) || (idx == IDX_CHROM);
  assign fits      = (idx == IDX_PGROM) ? addr_fits(ioctl_addr, PG_AW)
                                        : addr_fits(ioctl_addr, CH_AW);
  assign accept    = cand & known_idx & fits;
  assign ovf_hit   = cand & known_idx & ~fits;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (rise) begin
      state_d    = LOAD;
      hold_cnt_d = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (!ioctl_download) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end
        end
        HOLD: begin
          if (hold_cnt_q == CNT_LAST) begin
            state_d = IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sum_base   = rise ? 8'd0 : checksum_q;
    cnt_base   = rise ? 15'd0 : count_q;
    dn_index_d = rise ? ioctl_index : dn_index_q;
    overflow_d = (rise ? 1'b0 : overflow_q) | ovf_hit;
    dn_wr_d    = accept;
    dn_addr_d  = dn_addr_q;
    dn_data_d  = dn_data_q;
    checksum_d = sum_base;
    count_d    = cnt_base;
    if (accept) begin
      dn_addr_d  = ioctl_addr[13:0];
      dn_data_d  = ioctl_dout;
      checksum_d = sum_base + ioctl_dout;
      if (cnt_base != 15'h7FFF) begin
        count_d = cnt_base + 15'd1;
      end
    end
  end

  // Reset lands in HOLD so power-on reset is stretched like a finished load.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      dl_q       <= 1'b0;
      dn_addr_q  <= '0;
      dn_data_q  <= '0;
      dn_index_q <= '0;
      dn_wr_q    <= 1'b0;
      overflow_q <= 1'b0;
      checksum_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      dl_q       <= ioctl_download;
      dn_addr_q  <= dn_addr_d;
      dn_data_q  <= dn_data_d;
      dn_index_q <= dn_index_d;
      dn_wr_q    <= dn_wr_d;
      overflow_q <= overflow_d;
      checksum_q <= checksum_d;
      count_q    <= count_d;
    end
  end

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_index   = dn_index_q;
  assign dn_wr      = dn_wr_q;
  assign overflow   = overflow_q;
  assign checksum   = checksum_q;
  assign byte_count = count_q;
  assign sys_reset  = (state_q != IDLE);
  assign busy       = (state_q == LOAD);

endmodule

// File: tb/tb_download_ctrl.sv
// Scoreboard bench for download_ctrl: expected writes are queued by the
// stimulus and popped by a monitor whenever dn_wr is seen.
module tb_download_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [13:0] dn_addr;
  logic [7:0]  dn_data;
  logic [7:0]  dn_index;
  logic        dn_wr;
  logic        sys_reset;
  logic        busy;
  logic        overflow;
  logic [7:0]  checksum;
  logic [14:0] byte_count;

  download_ctrl dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_index      (dn_index),
    .dn_wr         (dn_wr),
    .sys_reset     (sys_reset),
    .busy          (busy),
    .overflow      (overflow),
    .checksum      (checksum),
    .byte_count    (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every dn_wr pulse must match the oldest queued write.
  always @(negedge clk_sys) begin
    if (!reset && dn_wr) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dn_wr: got addr 0x%0h data 0x%0h expected no write",
                 dn_addr, dn_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dn_addr !== e.addr || dn_data !== e.data) begin
          errors++;
          $display("FAIL dn_write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   dn_addr, dn_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input logic expect_wr);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (expect_wr) sb.push_back({a[13:0], d});
    tick();
    ioctl_wr = 1'b0;
  endtask

  // Drops download and measures ticks until sys_reset falls (fall cycle + 16 hold).
  task automatic end_download();
    int n;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (sys_reset && n < 40);
    check("hold_length", n, 17);
  endtask

  initial begin
    #2 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Power-on stretch
    check("rst_dn_wr", dn_wr, 0);
    check("rst_checksum", checksum, 0);
    check("rst_count", byte_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dn_index", dn_index, 0);
    check("rst_dn_addr", dn_addr, 0);
    check("rst_busy", busy, 0);
    repeat (15) tick();
    check("por_sys_reset_hi", sys_reset, 1);
    tick();
    check("por_sys_reset_lo", sys_reset, 0);

    // Index 0, three back-to-back bytes, first on the rise cycle
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    check("idle_before_rise", sys_reset, 0);
    wr_byte(25'd0, 8'h12, 1'b1);
    check("rise_busy", busy, 1);
    check("rise_sys_reset", sys_reset, 1);
    wr_byte(25'd1, 8'h34, 1'b1);
    wr_byte(25'd2, 8'h56, 1'b1);
    tick();
    check("pg_checksum", checksum, 8'h9C);
    check("pg_count", byte_count, 3);
    check("pg_overflow", overflow, 0);
    check("pg_dn_index", dn_index, 0);
    end_download();
    check("pg_checksum_held", checksum, 8'h9C);

    // Index 1, one out-of-range then one in-range byte
    ioctl_download = 1'b1;
    ioctl_index    = 8'd1;
    wr_byte(25'h800, 8'h55, 1'b0);
    wr_byte(25'h7FF, 8'hAA, 1'b1);
    tick();
    check("ch_overflow", overflow, 1);
    check("ch_checksum", checksum, 8'hAA);
    check("ch_count", byte_count, 1);
    check("ch_dn_index", dn_index, 1);
    check("ch_dn_addr_held", dn_addr, 14'h7FF);
    end_download();
    check("ch_overflow_held", overflow, 1);

    // Unknown index: everything discarded silently
    ioctl_download = 1'b1;
    ioctl_index    = 8'd5;
    for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'(8'h40 + i), 1'b0);
    check("x_checksum", checksum, 0);
    check("x_overflow", overflow, 0);
    check("x_count", byte_count, 0);
    check("x_dn_index", dn_index, 5);
    check("x_busy", busy, 1);
    end_download();

    // Re-rise five cycles into HOLD keeps sys_reset high and clears stats
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    wr_byte(25'd5, 8'h01, 1'b1);
    wr_byte(25'd6, 8'h02, 1'b1);
    tick();
    check("rr_checksum_pre", checksum, 8'h03);
    ioctl_download = 1'b0;
    tick();
    check("rr_hold_busy", busy, 0);
    begin
      int lows;
      lows = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (!sys_reset) lows++;
      end
      check("rr_sys_reset_low_cycles", lows, 0);
    end
    ioctl_download = 1'b1;
    tick();
    check("rr_sys_reset", sys_reset, 1);
    check("rr_busy", busy, 1);
    check("rr_checksum_clr", checksum, 0);
    check("rr_count_clr", byte_count, 0);
    wr_byte(25'd3, 8'h10, 1'b1);
    tick();
    check("rr_checksum", checksum, 8'h10);
    check("rr_count", byte_count, 1);
    end_download();

    // Async reset mid-LOAD drops the in-flight write
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    wr_byte(25'd4, 8'h77, 1'b1);
    wr_byte(25'd5, 8'h88, 1'b0);
    reset = 1'b1;
    #1;
    check("ar_dn_wr", dn_wr, 0);
    check("ar_checksum", checksum, 0);
    check("ar_count", byte_count, 0);
    check("ar_sys_reset", sys_reset, 1);
    check("ar_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();
    check("ar_release_busy", busy, 1);
    check("ar_release_dn_wr", dn_wr, 0);
    wr_byte(25'd7, 8'h21, 1'b1);
    tick();
    check("ar_checksum_new", checksum, 8'h21);
    check("ar_count_new", byte_count, 1);
    end_download();

    tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
